// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Operands are registered toward the ALU, the result is sampled after a fixed settle time.
module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SEL_WIDTH   = 3,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [DATA_WIDTH-1:0] data1_a,
    input  logic [DATA_WIDTH-1:0] data2_a,
    input  logic [SEL_WIDTH-1:0]  select_a,
    input  logic [DATA_WIDTH-1:0] data1_b,
    input  logic [DATA_WIDTH-1:0] data2_b,
    input  logic [SEL_WIDTH-1:0]  select_b,
    output logic [DATA_WIDTH-1:0] alu_data1,
    output logic [DATA_WIDTH-1:0] alu_data2,
    output logic [SEL_WIDTH-1:0]  alu_select,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ack,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  resp_err
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic                  grant_q, grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] alu_data1_q, alu_data1_d;
    logic [DATA_WIDTH-1:0] alu_data2_q, alu_data2_d;
    logic [SEL_WIDTH-1:0]  alu_select_q, alu_select_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  resp_err_q, resp_err_d;
    logic [1:0]            resp_valid_q, resp_valid_d;
    logic                  gnt_c;
    logic                  gnt_vld_c;

    // Round-robin pick: on contention the requester not served last wins.
    always_comb begin
        gnt_vld_c = 1'b1;
        gnt_c     = 1'b0;
        case (req_valid)
            2'b01:   gnt_c = 1'b0;
            2'b10:   gnt_c = 1'b1;
            2'b11:   gnt_c = ~last_grant_q;
            default: gnt_vld_c = 1'b0;
        endcase
    end

    // Ready is combinational so a requester may withdraw before acceptance; held low in reset.
    assign req_ready = (state_q == IDLE && gnt_vld_c && rst_n) ? (2'b01 << gnt_c) : 2'b00;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        alu_data1_d  = alu_data1_q;
        alu_data2_d  = alu_data2_q;
        alu_select_d = alu_select_q;
        result_d     = result_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld_c) begin
                    state_d = EXEC;
                    grant_d = gnt_c;
                    cnt_d   = '0;
                    if (gnt_c) begin
                        alu_data1_d  = data1_b;
                        alu_data2_d  = data2_b;
                        alu_select_d = select_b;
                    end else begin
                        alu_data1_d  = data1_a;
                        alu_data2_d  = data2_a;
                        alu_select_d = select_a;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 2'b01 << grant_q;
                    // Select codes with the top bit set are not ALU operations.
                    if (alu_select_q[SEL_WIDTH-1]) begin
                        result_d   = '0;
                        resp_err_d = 1'b1;
                    end else begin
                        result_d   = alu_result;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ack[grant_q]) begin
                    state_d      = IDLE;
                    resp_valid_d = 2'b00;
                    resp_err_d   = 1'b0;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            alu_data1_q  <= '0;
            alu_data2_q  <= '0;
            alu_select_q <= '0;
            result_q     <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            alu_data1_q  <= alu_data1_d;
            alu_data2_q  <= alu_data2_d;
            alu_select_q <= alu_select_d;
            result_q     <= result_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign alu_data1  = alu_data1_q;
    assign alu_data2  = alu_data2_q;
    assign alu_select = alu_select_q;
    assign result     = result_q;
    assign resp_err   = resp_err_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: default instance (settle 2) and a settle-4 instance,
// both driving a behavioural ALU.
module tb_alu_share_arbiter;

    localparam int unsigned DW = 8;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_ready, resp_valid, resp_ack;
    logic [DW-1:0] data1_a, data2_a, data1_b, data2_b;
    logic [SW-1:0] select_a, select_b;
    logic [DW-1:0] alu_data1, alu_data2, alu_result, result;
    logic [SW-1:0] alu_select;
    logic          resp_err;

    logic [1:0]    req_valid4, req_ready4, resp_valid4, resp_ack4;
    logic [DW-1:0] data1_a4, data2_a4;
    logic [DW-1:0] alu_data1_4, alu_data2_4, alu_result4, result4;
    logic [SW-1:0] select_a4, alu_select4;
    logic          resp_err4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                            input logic [SW-1:0] sel);
        case (sel)
            3'b000:  return d2;
            3'b001:  return d1 + d2;
            3'b010:  return d1 & d2;
            3'b011:  return d1 | d2;
            default: return 8'hEE;
        endcase
    endfunction

    assign alu_result  = alu_f(alu_data1, alu_data2, alu_select);
    assign alu_result4 = alu_f(alu_data1_4, alu_data2_4, alu_select4);

    alu_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .data1_a(data1_a), .data2_a(data2_a), .select_a(select_a),
        .data1_b(data1_b), .data2_b(data2_b), .select_b(select_b),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ack(resp_ack),
        .result(result), .resp_err(resp_err)
    );

    alu_share_arbiter #(.WAIT_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid4), .req_ready(req_ready4),
        .data1_a(data1_a4), .data2_a(data2_a4), .select_a(select_a4),
        .data1_b(8'd0), .data2_b(8'd0), .select_b(3'd0),
        .alu_data1(alu_data1_4), .alu_data2(alu_data2_4), .alu_select(alu_select4),
        .alu_result(alu_result4),
        .resp_valid(resp_valid4), .resp_ack(resp_ack4),
        .result(result4), .resp_err(resp_err4)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":req_ready"}, 8'(req_ready), 8'd0);
        check({tag, ":resp_valid"}, 8'(resp_valid), 8'd0);
        check({tag, ":result"}, result, 8'd0);
        check({tag, ":resp_err"}, 8'(resp_err), 8'd0);
        check({tag, ":alu_data1"}, alu_data1, 8'd0);
        check({tag, ":alu_data2"}, alu_data2, 8'd0);
        check({tag, ":alu_select"}, 8'(alu_select), 8'd0);
    endtask

    // Requester g is presented and expected to win; runs accept..ack at settle 2.
    task automatic run_op(input string tag, input int g, input logic [7:0] exp_res,
                          input logic exp_err);
        logic [1:0] oh;
        oh = 2'b01 << g;
        check({tag, ":ready"}, 8'(req_ready), 8'(oh));
        tick;
        req_valid[g] = 1'b0;
        check({tag, ":c1_ready"}, 8'(req_ready), 8'd0);
        check({tag, ":c1_valid"}, 8'(resp_valid), 8'd0);
        tick;
        check({tag, ":c2_valid"}, 8'(resp_valid), 8'd0);
        tick;
        check({tag, ":c3_valid"}, 8'(resp_valid), 8'(oh));
        check({tag, ":c3_result"}, result, exp_res);
        check({tag, ":c3_err"}, 8'(resp_err), 8'(exp_err));
        resp_ack = oh;
        tick;
        resp_ack = 2'b00;
        check({tag, ":ack_valid"}, 8'(resp_valid), 8'd0);
        check({tag, ":ack_err"}, 8'(resp_err), 8'd0);
        check({tag, ":ack_result"}, result, exp_res);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; resp_ack = 2'b00;
        data1_a = '0; data2_a = '0; select_a = '0;
        data1_b = '0; data2_b = '0; select_b = '0;
        req_valid4 = 2'b00; resp_ack4 = 2'b00;
        data1_a4 = '0; data2_a4 = '0; select_a4 = '0;
        #12;
        check_all_zero("rst");
        rst_n = 1'b1;
        tick;

        // single add
        data1_a = 8'd10; data2_a = 8'd20; select_a = 3'b001; req_valid = 2'b01;
        #1;
        check("t1:alu_before", 8'(alu_select), 8'd0);
        run_op("t1", 0, 8'd30, 1'b0);
        check("t1:alu_held", 8'(alu_select), 8'd1);

        // contention from a fresh reset
        do_reset;
        data1_a = 8'd10; data2_a = 8'd20; select_a = 3'b010;
        data1_b = 8'd5;  data2_b = 8'd10; select_b = 3'b011;
        req_valid = 2'b11;
        #1;
        run_op("t2a", 0, 8'd0, 1'b0);
        run_op("t2b", 1, 8'd15, 1'b0);
        req_valid = 2'b11;
        #1;
        run_op("t2c", 0, 8'd0, 1'b0);
        req_valid = 2'b00;

        // back-pressure with B waiting, stray ack on B ignored
        data1_a = 8'd1; data2_a = 8'd2; select_a = 3'b001; req_valid = 2'b01;
        #1;
        check("t3:ready", 8'(req_ready), 8'd1);
        tick;
        req_valid = 2'b10;
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3:hold%0d_valid", i), 8'(resp_valid), 8'd1);
            check($sformatf("t3:hold%0d_result", i), result, 8'd3);
            check($sformatf("t3:hold%0d_ready", i), 8'(req_ready), 8'd0);
            resp_ack = 2'b10;
            tick;
        end
        resp_ack = 2'b01;
        tick;
        resp_ack = 2'b00;
        check("t3:after_ack_valid", 8'(resp_valid), 8'd0);
        check("t3:after_ack_ready", 8'(req_ready), 8'd2);
        run_op("t3b", 1, 8'd15, 1'b0);

        // forward and illegal select
        data1_a = 8'd99; data2_a = 8'd20; select_a = 3'b000; req_valid = 2'b01;
        #1;
        run_op("t4a", 0, 8'd20, 1'b0);
        data1_b = 8'd5; data2_b = 8'd10; select_b = 3'b101; req_valid = 2'b10;
        #1;
        run_op("t4b", 1, 8'd0, 1'b1);

        // reset during execution, request held throughout
        data1_a = 8'd10; data2_a = 8'd20; select_a = 3'b001; req_valid = 2'b01;
        #1;
        check("t5:ready", 8'(req_ready), 8'd1);
        tick;
        check("t5:exec_select", 8'(alu_select), 8'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5rst");
        #3;
        rst_n = 1'b1;
        #1;
        run_op("t5", 0, 8'd30, 1'b0);

        // wrap-around add at settle 4
        data1_a4 = 8'd200; data2_a4 = 8'd100; select_a4 = 3'b001; req_valid4 = 2'b01;
        #1;
        check("t6:ready", 8'(req_ready4), 8'd1);
        tick;
        req_valid4 = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("t6:c%0d_valid", k), 8'(resp_valid4), 8'd0);
            tick;
        end
        check("t6:c5_valid", 8'(resp_valid4), 8'd1);
        check("t6:c5_result", result4, 8'd44);
        check("t6:c5_err", 8'(resp_err4), 8'd0);
        resp_ack4 = 2'b01;
        tick;
        resp_ack4 = 2'b00;
        check("t6:ack_valid", 8'(resp_valid4), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
